mips_data_memory: RTL and testbench

//  Data memory stage of the single-cycle MIPS datapath; consumes the ALU result as a byte address.

---
 rtl/mips_pkg.sv | 31 +++
 rtl/mips_load_align.sv | 29 ++
 rtl/mips_data_memory.sv | 107 ++++++++++
 tb/tb_mips_data_memory.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath memory blocks: access sizes,
// byte-lane numbering and byte-enable decoding.
package mips_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_RSVD = 2'b11
  } mem_size_t;

  localparam int DEPTH_WORDS_DEFAULT = 256;

  // Little-endian lanes: lane 0 holds bits 7:0.
  localparam logic [1:0] LANE_0 = 2'd0;
  localparam logic [1:0] LANE_1 = 2'd1;
  localparam logic [1:0] LANE_2 = 2'd2;
  localparam logic [1:0] LANE_3 = 2'd3;

  function automatic logic [3:0] byte_enable(input mem_size_t size, input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b1111;
    case (size)
      MEM_BYTE: be = 4'b0001 << lane;
      MEM_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      default:  be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mips_load_align.sv
// Selects the addressed byte/halfword of a raw memory word and sign- or
// zero-extends it to 32 bits for write-back.
module mips_load_align
  import mips_pkg::*;
(
  input  logic [31:0] raw_word,
  input  logic [1:0]  byte_sel,
  input  mem_size_t   mem_size,
  input  logic        mem_unsigned,
  output logic [31:0] read_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte  = raw_word[{byte_sel, 3'b000} +: 8];
    sel_half  = byte_sel[1] ? raw_word[31:16] : raw_word[15:0];
    read_data = raw_word;
    case (mem_size)
      MEM_BYTE: read_data = mem_unsigned ? {24'h000000, sel_byte}
                                         : {{24{sel_byte[7]}}, sel_byte};
      MEM_HALF: read_data = mem_unsigned ? {16'h0000, sel_half}
                                         : {{16{sel_half[15]}}, sel_half};
      default:  read_data = raw_word;
    endcase
  end

endmodule

// File: rtl/mips_data_memory.sv
// Single-cycle MIPS data memory: combinational loads, byte-lane stores at the
// clock edge, misalignment suppression and sticky first-fault capture.
module mips_data_memory
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemUnsigned,
  output logic [31:0] ReadData,
  output logic        Misaligned,
  output logic        FaultValid,
  output logic [31:0] FaultAddr
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] mem_d [DEPTH_WORDS];
  logic        fault_valid_q, fault_valid_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  mem_size_t         size;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] word_idx;
  logic [3:0]        be;
  logic [31:0]       store_data;
  logic [31:0]       aligned_data;
  logic              misaligned;

  assign size     = mem_size_t'(MemSize);
  assign lane     = Address[1:0];
  assign word_idx = Address[ADDR_W+1:2];

  // Reserved size behaves as a word access everywhere.
  always_comb begin
    misaligned = 1'b0;
    case (size)
      MEM_BYTE: misaligned = 1'b0;
      MEM_HALF: misaligned = Address[0];
      default:  misaligned = (lane != LANE_0);
    endcase
    misaligned = misaligned & (MemRead | MemWrite);
  end

  always_comb begin
    be         = byte_enable(size, lane);
    store_data = WriteData;
    case (size)
      MEM_BYTE: store_data = {4{WriteData[7:0]}};
      MEM_HALF: store_data = {2{WriteData[15:0]}};
      default:  store_data = WriteData;
    endcase
  end

  mips_load_align u_load_align (
    .raw_word     (mem_q[word_idx]),
    .byte_sel     (lane),
    .mem_size     (size),
    .mem_unsigned (MemUnsigned),
    .read_data    (aligned_data)
  );

  assign ReadData   = (MemRead && !misaligned) ? aligned_data : 32'h0000_0000;
  assign Misaligned = misaligned;
  assign FaultValid = fault_valid_q;
  assign FaultAddr  = fault_addr_q;

  always_comb begin
    mem_d = mem_q;
    if (MemWrite && !misaligned) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_d[word_idx][8*i +: 8] = store_data[8*i +: 8];
        end
      end
    end
  end

  // Only the first misaligned access is recorded until the next reset.
  always_comb begin
    fault_valid_d = fault_valid_q;
    fault_addr_d  = fault_addr_q;
    if (misaligned && !fault_valid_q) begin
      fault_valid_d = 1'b1;
      fault_addr_d  = Address;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q         <= '{default: 32'h0000_0000};
      fault_valid_q <= 1'b0;
      fault_addr_q  <= 32'h0000_0000;
    end else begin
      mem_q         <= mem_d;
      fault_valid_q <= fault_valid_d;
      fault_addr_q  <= fault_addr_d;
    end
  end

endmodule

// File: tb/tb_mips_data_memory.sv
// Directed bench for mips_data_memory: table of load/store vectors followed
// by hand-written fault, same-cycle read/write and reset sequences.
module tb_mips_data_memory;

  logic        clk;
  logic        reset;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] read_data;
  logic        misaligned;
  logic        fault_valid;
  logic [31:0] fault_addr;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rdata;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  mips_data_memory dut (
    .clk         (clk),
    .reset       (reset),
    .Address     (address),
    .WriteData   (write_data),
    .MemRead     (mem_read),
    .MemWrite    (mem_write),
    .MemSize     (mem_size),
    .MemUnsigned (mem_unsigned),
    .ReadData    (read_data),
    .Misaligned  (misaligned),
    .FaultValid  (fault_valid),
    .FaultAddr   (fault_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one access mid-cycle and let combinational outputs settle.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] wd,
                               input logic rd, input logic wr,
                               input logic [1:0] sz, input logic uns);
    @(negedge clk);
    address      = a;
    write_data   = wd;
    mem_read     = rd;
    mem_write    = wr;
    mem_size     = sz;
    mem_unsigned = uns;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  function automatic void add_vec(input string name, input logic [31:0] a,
                                  input logic [31:0] wd, input logic rd,
                                  input logic wr, input logic [1:0] sz,
                                  input logic uns, input logic [31:0] er,
                                  input logic em);
    vec_t v;
    v.name = name; v.addr = a; v.wdata = wd; v.rd = rd; v.wr = wr;
    v.size = sz; v.uns = uns; v.exp_rdata = er; v.exp_mis = em;
    vecs.push_back(v);
  endfunction

  initial begin
    // Size codes: 0 byte, 1 half, 2 word
    add_vec("sw_10",        32'h10,  32'h8899AABB, 0, 1, 2'd2, 0, 32'h0,        0);
    add_vec("lw_10",        32'h10,  32'h0,        1, 0, 2'd2, 0, 32'h8899AABB, 0);
    add_vec("lb_10",        32'h10,  32'h0,        1, 0, 2'd0, 0, 32'hFFFFFFBB, 0);
    add_vec("lbu_13",       32'h13,  32'h0,        1, 0, 2'd0, 1, 32'h00000088, 0);
    add_vec("lb_12",        32'h12,  32'h0,        1, 0, 2'd0, 0, 32'hFFFFFF99, 0);
    add_vec("lh_12",        32'h12,  32'h0,        1, 0, 2'd1, 0, 32'hFFFF8899, 0);
    add_vec("lw_rsvd_10",   32'h10,  32'h0,        1, 0, 2'd3, 1, 32'h8899AABB, 0);
    add_vec("noread_10",    32'h10,  32'h0,        0, 0, 2'd2, 0, 32'h0,        0);
    add_vec("sb_21",        32'h21,  32'h0000007F, 0, 1, 2'd0, 0, 32'h0,        0);
    add_vec("lw_20",        32'h20,  32'h0,        1, 0, 2'd2, 0, 32'h00007F00, 0);
    add_vec("lh_20",        32'h20,  32'h0,        1, 0, 2'd1, 0, 32'h00007F00, 0);
    add_vec("lhu_22",       32'h22,  32'h0,        1, 0, 2'd1, 1, 32'h00000000, 0);
    add_vec("sh_42",        32'h42,  32'hAAAA1234, 0, 1, 2'd1, 0, 32'h0,        0);
    add_vec("sh_40",        32'h40,  32'h5555F00D, 0, 1, 2'd1, 0, 32'h0,        0);
    add_vec("lw_40",        32'h40,  32'h0,        1, 0, 2'd2, 0, 32'h1234F00D, 0);
    add_vec("lh_40",        32'h40,  32'h0,        1, 0, 2'd1, 0, 32'hFFFFF00D, 0);
    add_vec("lhu_42",       32'h42,  32'h0,        1, 0, 2'd1, 1, 32'h00001234, 0);
    add_vec("lb_41",        32'h41,  32'h0,        1, 0, 2'd0, 0, 32'hFFFFFFF0, 0);
    add_vec("lbu_41",       32'h41,  32'h0,        1, 0, 2'd0, 1, 32'h000000F0, 0);
    add_vec("sw_400_wrap",  32'h400, 32'hCAFE0001, 0, 1, 2'd2, 0, 32'h0,        0);
    add_vec("lw_000_wrap",  32'h000, 32'h0,        1, 0, 2'd2, 0, 32'hCAFE0001, 0);

    reset = 1'b1;
    address = '0; write_data = '0; mem_read = 0; mem_write = 0;
    mem_size = 2'd2; mem_unsigned = 0;
    #12;
    checkOutput("reset_rdata", read_data, 32'h0);
    checkOutput("reset_mis", {31'h0, misaligned}, 32'h0);
    checkOutput("reset_fvalid", {31'h0, fault_valid}, 32'h0);
    checkOutput("reset_faddr", fault_addr, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].wr,
                    vecs[i].size, vecs[i].uns);
      checkOutput({vecs[i].name, "_rdata"}, read_data, vecs[i].exp_rdata);
      checkOutput({vecs[i].name, "_mis"}, {31'h0, misaligned}, {31'h0, vecs[i].exp_mis});
      checkOutput({vecs[i].name, "_fvalid"}, {31'h0, fault_valid}, 32'h0);
    end

    // Misaligned store: suppressed, fault captured at the edge
    applyStimulus(32'h13, 32'hDEADBEEF, 0, 1, 2'd2, 0);
    checkOutput("sw13_mis", {31'h0, misaligned}, 32'h1);
    checkOutput("sw13_fvalid_pre", {31'h0, fault_valid}, 32'h0);
    applyStimulus(32'h10, 32'h0, 1, 0, 2'd2, 0);
    checkOutput("sw13_word_kept", read_data, 32'h8899AABB);
    checkOutput("sw13_fvalid", {31'h0, fault_valid}, 32'h1);
    checkOutput("sw13_faddr", fault_addr, 32'h13);
    applyStimulus(32'h51, 32'h0, 1, 0, 2'd1, 0);
    checkOutput("lh51_mis", {31'h0, misaligned}, 32'h1);
    checkOutput("lh51_rdata", read_data, 32'h0);
    applyStimulus(32'h10, 32'h0, 0, 0, 2'd2, 0);
    checkOutput("lh51_faddr_held", fault_addr, 32'h13);
    checkOutput("lh51_fvalid", {31'h0, fault_valid}, 32'h1);

    // Read and write the same word in one cycle
    applyStimulus(32'h60, 32'h55AA1234, 1, 1, 2'd2, 0);
    checkOutput("rw60_old", read_data, 32'h0);
    applyStimulus(32'h61, 32'h000000EE, 1, 1, 2'd0, 1);
    checkOutput("rw61_old", read_data, 32'h00000012);
    applyStimulus(32'h60, 32'h0, 1, 0, 2'd2, 0);
    checkOutput("rw60_new", read_data, 32'h55AAEE34);

    // Reset asserted across an edge carrying a store
    applyStimulus(32'h10, 32'h11111111, 0, 1, 2'd2, 0);
    reset = 1'b1;
    #1;
    checkOutput("rst_fvalid", {31'h0, fault_valid}, 32'h0);
    checkOutput("rst_faddr", fault_addr, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    mem_write = 1'b0;
    applyStimulus(32'h10, 32'h0, 1, 0, 2'd2, 0);
    checkOutput("rst_lw_10", read_data, 32'h0);
    applyStimulus(32'h60, 32'h0, 1, 0, 2'd2, 0);
    checkOutput("rst_lw_60", read_data, 32'h0);
    applyStimulus(32'h40, 32'h0, 1, 0, 2'd2, 0);
    checkOutput("rst_lw_40", read_data, 32'h0);
    checkOutput("rst_fvalid_after", {31'h0, fault_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
